// File: rtl/parking_pkg.sv
// Shared definitions for the parking slot scanner.
//
// Contents:
//   NUM_SLOTS_DEF - default number of scanned slots
//   SLOT_IDX_W    - width of a slot index (covers up to 8 slots)
//   scan_state_e  - scan sequencer states
package parking_pkg;

   localparam int unsigned NUM_SLOTS_DEF = 4;
   localparam int unsigned SLOT_IDX_W    = 3;

   // DWELL drives one select low. NEXT is a one-cycle gap with no select
   // driven, so two slots are never selected at the same time.
   typedef enum logic [1:0] {
      IDLE,
      DWELL,
      NEXT
   } scan_state_e;

endpackage

// File: rtl/slot_debounce.sv
// Per-slot debouncer for the parking slot scanner.
//
// Holds the debounced occupancy of one slot and a counter of consecutive
// visits whose sample disagreed with it. The counter steps once per sample
// strobe, so debouncing counts scan visits, not clock cycles.
//
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   sample_en  - one-cycle strobe: this slot is being sampled this cycle
//   sample_val - synchronized sense value for this slot
//   occ        - debounced occupancy (registered)
//   toggle     - combinational: occ flips on the coming clock edge
module slot_debounce #(
   parameter int unsigned DB_COUNT = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sample_en,
   input  logic sample_val,
   output logic occ,
   output logic toggle
);

   localparam logic [3:0] DbLimit = 4'(DB_COUNT);

   logic [3:0] cnt_q, cnt_d;
   logic       occ_q, occ_d;

   always_comb begin
      cnt_d  = cnt_q;
      occ_d  = occ_q;
      toggle = 1'b0;
      if (sample_en) begin
         if (sample_val == occ_q) begin
            // Any agreeing visit restarts the run of disagreements.
            cnt_d = 4'd0;
         end else if (cnt_q + 4'd1 == DbLimit) begin
            occ_d  = ~occ_q;
            cnt_d  = 4'd0;
            toggle = 1'b1;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= 4'd0;
         occ_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         occ_q <= occ_d;
      end
   end

   assign occ = occ_q;

endmodule

// File: rtl/parking_slot_scanner.sv
// Multiplexed car-presence scanner for the parking system.
//
// Walks an active-low one-hot select across NUM_SLOTS slots, dwelling
// SCAN_DIV cycles on each, and samples the shared sense line once per
// visit at dwell count SETTLE. Each slot is debounced across visits; the
// debounced occupancy, free-slot count and arrive/depart events are
// published to the parking FSM.
//
// Ports:
//   clk          - system clock
//   reset_n      - asynchronous active-low reset
//   scan_en      - 1 = scanning runs, 0 = scanning pauses
//   sense        - shared sensor return, asynchronous, 1 = car present
//   slot_sel     - active-low one-hot select, all ones = none selected
//   occupied     - debounced occupancy, bit i = slot i
//   free_count   - NUM_SLOTS minus number of occupied slots
//   occ_valid    - occupancy has been through enough rounds to trust
//   arrive_pulse - one-cycle strobe on a slot going 0->1
//   depart_pulse - one-cycle strobe on a slot going 1->0
//   event_slot   - slot index of the latest reported event
module parking_slot_scanner
   import parking_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
   parameter int unsigned SCAN_DIV  = 40000,
   parameter int unsigned SETTLE    = 8,
   parameter int unsigned DB_COUNT  = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  scan_en,
   input  logic                  sense,
   output logic [NUM_SLOTS-1:0]  slot_sel,
   output logic [NUM_SLOTS-1:0]  occupied,
   output logic [3:0]            free_count,
   output logic                  occ_valid,
   output logic                  arrive_pulse,
   output logic                  depart_pulse,
   output logic [SLOT_IDX_W-1:0] event_slot
);

   localparam int unsigned DwellW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;

   localparam logic [DwellW-1:0]     DwellLast = DwellW'(SCAN_DIV - 1);
   localparam logic [DwellW-1:0]     SettleCnt = DwellW'(SETTLE);
   localparam logic [SLOT_IDX_W-1:0] LastIdx   = SLOT_IDX_W'(NUM_SLOTS - 1);
   localparam logic [3:0]            RoundMax  = 4'(DB_COUNT);

   // ------------------------------------------------------------------
   // Sense synchronizer
   // ------------------------------------------------------------------
   logic sync1_q, sync2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sense;
         sync2_q <= sync1_q;
      end
   end

   // ------------------------------------------------------------------
   // Scan sequencer
   // ------------------------------------------------------------------
   scan_state_e           state_q, state_d;
   logic [SLOT_IDX_W-1:0] idx_q, idx_d;
   logic [DwellW-1:0]     dwell_q, dwell_d;
   logic [3:0]            round_q, round_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dwell_d = dwell_q;
      round_d = round_q;
      if (!scan_en) begin
         // Pausing keeps the slot index, so resuming revisits the same
         // slot from the start of its dwell.
         state_d = IDLE;
         dwell_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = DWELL;
               dwell_d = '0;
            end
            DWELL: begin
               if (dwell_q == DwellLast) begin
                  state_d = NEXT;
                  dwell_d = '0;
               end else begin
                  dwell_d = dwell_q + 1'b1;
               end
            end
            NEXT: begin
               state_d = DWELL;
               if (idx_q == LastIdx) begin
                  idx_d = '0;
                  if (round_q != RoundMax) begin
                     round_d = round_q + 4'd1;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               dwell_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         dwell_q <= '0;
         round_q <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dwell_q <= dwell_d;
         round_q <= round_d;
      end
   end

   // Select is decoded straight from the state register so it follows the
   // sequencer on the same edge.
   always_comb begin
      slot_sel = '1;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         if (state_q == DWELL && idx_q == SLOT_IDX_W'(i)) begin
            slot_sel[i] = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-slot debouncers
   // ------------------------------------------------------------------
   logic                 sample_strobe;
   logic [NUM_SLOTS-1:0] sample_en;
   logic [NUM_SLOTS-1:0] occ_vec;
   logic [NUM_SLOTS-1:0] toggle_vec;

   assign sample_strobe = (state_q == DWELL) && (dwell_q == SettleCnt);

   always_comb begin
      sample_en = '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         sample_en[i] = sample_strobe && (idx_q == SLOT_IDX_W'(i));
      end
   end

   for (genvar g = 0; g < int'(NUM_SLOTS); g++) begin : g_slot
      slot_debounce #(
         .DB_COUNT (DB_COUNT)
      ) u_slot_debounce (
         .clk        (clk),
         .reset_n    (reset_n),
         .sample_en  (sample_en[g]),
         .sample_val (sync2_q),
         .occ        (occ_vec[g]),
         .toggle     (toggle_vec[g])
      );
   end

   assign occupied = occ_vec;

   // ------------------------------------------------------------------
   // Free-slot count
   // ------------------------------------------------------------------
   logic [3:0] occ_pop;

   always_comb begin
      occ_pop = 4'd0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         occ_pop = occ_pop + {3'b000, occ_vec[i]};
      end
   end

   assign free_count = 4'(NUM_SLOTS) - occ_pop;

   // ------------------------------------------------------------------
   // Validity and events
   // ------------------------------------------------------------------
   logic                  occ_valid_q, occ_valid_d;
   logic                  arrive_q, arrive_d;
   logic                  depart_q, depart_d;
   logic [SLOT_IDX_W-1:0] event_slot_q, event_slot_d;

   // Only the sampled slot can toggle, so OR-reducing the toggle vector
   // picks out that slot without an index mux. Events stay masked until
   // the first full debounce has been given a chance to settle.
   always_comb begin
      occ_valid_d  = occ_valid_q | (round_q == RoundMax);
      arrive_d     = occ_valid_q && |(toggle_vec & ~occ_vec);
      depart_d     = occ_valid_q && |(toggle_vec & occ_vec);
      event_slot_d = event_slot_q;
      if (arrive_d || depart_d) begin
         event_slot_d = idx_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ_valid_q  <= 1'b0;
         arrive_q     <= 1'b0;
         depart_q     <= 1'b0;
         event_slot_q <= '0;
      end else begin
         occ_valid_q  <= occ_valid_d;
         arrive_q     <= arrive_d;
         depart_q     <= depart_d;
         event_slot_q <= event_slot_d;
      end
   end

   assign occ_valid    = occ_valid_q;
   assign arrive_pulse = arrive_q;
   assign depart_pulse = depart_q;
   assign event_slot   = event_slot_q;

endmodule

// File: tb/tb_parking_slot_scanner.sv
// Bench for parking_slot_scanner (NUM_SLOTS=4, SCAN_DIV=16, SETTLE=4,
// DB_COUNT=3). A small parking lot model drives sense from the select
// lines; expected events are queued by the stimulus and checked by an
// independent monitor whenever the DUT strobes arrive or depart.
module tb_parking_slot_scanner;

   localparam int unsigned NS = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          scan_en;
   logic          sense;
   logic [NS-1:0] slot_sel;
   logic [NS-1:0] occupied;
   logic [3:0]    free_count;
   logic          occ_valid;
   logic          arrive_pulse;
   logic          depart_pulse;
   logic [2:0]    event_slot;

   // Cars physically present; sense reports the selected slot only.
   logic [NS-1:0] car = '0;
   assign sense = |(~slot_sel & car);

   always #5 clk = ~clk;

   parking_slot_scanner #(
      .NUM_SLOTS (NS),
      .SCAN_DIV  (16),
      .SETTLE    (4),
      .DB_COUNT  (3)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .scan_en      (scan_en),
      .sense        (sense),
      .slot_sel     (slot_sel),
      .occupied     (occupied),
      .free_count   (free_count),
      .occ_valid    (occ_valid),
      .arrive_pulse (arrive_pulse),
      .depart_pulse (depart_pulse),
      .event_slot   (event_slot)
   );

   typedef struct {
      bit         is_arrive;
      logic [2:0] slot;
      logic [3:0] occ;
      logic [3:0] free;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every event strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset_n && (arrive_pulse || depart_pulse)) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: arrive=%0b depart=%0b slot=%0d", arrive_pulse,
                     depart_pulse, event_slot);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("ev_arrive", 32'(arrive_pulse), 32'(e.is_arrive));
            check("ev_depart", 32'(depart_pulse), 32'(!e.is_arrive));
            check("ev_slot", 32'(event_slot), 32'(e.slot));
            check("ev_occupied", 32'(occupied), 32'(e.occ));
            check("ev_free_count", 32'(free_count), 32'(e.free));
         end
      end
   end

   // Called in the #1-after-posedge phase; waits for a select pattern.
   task automatic wait_sel(input logic [NS-1:0] pat, input int budget, input string name);
      int n = 0;
      while (slot_sel !== pat && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (slot_sel !== pat) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: timeout, slot_sel %b, expected %b", name, slot_sel, pat);
      end
   endtask

   task automatic wait_visit_end(input int slot, input string name);
      logic [NS-1:0] pat;
      pat = '1;
      pat[slot] = 1'b0;
      wait_sel(pat, 100, name);
      wait_sel('1, 40, name);
   endtask

   task automatic wait_sb_empty(input int budget, input string name);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset_n = 1'b0;
      scan_en = 1'b1;
      car     = 4'b0100;   // slot 2 occupied from power-up

      // Reset values while held in reset.
      repeat (3) @(posedge clk);
      #1;
      check("rst_slot_sel", 32'(slot_sel), 32'hF);
      check("rst_occupied", 32'(occupied), 32'h0);
      check("rst_free_count", 32'(free_count), 32'd4);
      check("rst_occ_valid", 32'(occ_valid), 32'd0);
      check("rst_pulses", 32'({arrive_pulse, depart_pulse}), 32'd0);
      check("rst_event_slot", 32'(event_slot), 32'd0);

      // First select and break-before-make.
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_sel", 32'(slot_sel), 32'hE);
      repeat (15) @(posedge clk);
      #1;
      check("dwell_last_sel", 32'(slot_sel), 32'hE);
      @(posedge clk);
      #1;
      check("gap_sel", 32'(slot_sel), 32'hF);
      @(posedge clk);
      #1;
      check("second_sel", 32'(slot_sel), 32'hD);

      // Power-up: slot 2 settles silently before occ_valid.
      n = 0;
      while (!occ_valid && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("occ_valid_rise", 32'(occ_valid), 32'd1);
      check("pwr_occupied", 32'(occupied), 32'h4);
      check("pwr_free_count", 32'(free_count), 32'd3);

      // Arrival in slot 1.
      sb.push_back('{is_arrive: 1'b1, slot: 3'd1, occ: 4'b0110, free: 4'd2});
      car[1] = 1'b1;
      wait_sb_empty(300, "arrive_seen");
      repeat (3) @(posedge clk);
      #1;
      check("arrive_event_held", 32'(event_slot), 32'd1);
      check("arrive_pulse_low", 32'(arrive_pulse), 32'd0);

      // Glitch: two high visits, one low, two high again. The low visit
      // must clear the count, so slot 3 never flips.
      wait_sel(4'b1110, 100, "glitch_start");
      car[3] = 1'b1;
      wait_visit_end(3, "glitch_v1");
      wait_visit_end(3, "glitch_v2");
      car[3] = 1'b0;
      wait_visit_end(3, "glitch_v3");
      check("glitch_occ_mid", 32'(occupied), 32'h6);
      car[3] = 1'b1;
      wait_visit_end(3, "glitch_v4");
      wait_visit_end(3, "glitch_v5");
      car[3] = 1'b0;
      check("glitch_occupied", 32'(occupied), 32'h6);
      check("glitch_free_count", 32'(free_count), 32'd2);

      // Departure from slot 2 with a pause early in the 2nd visit.
      wait_sel(4'b1110, 100, "depart_start");
      car[2] = 1'b0;
      sb.push_back('{is_arrive: 1'b0, slot: 3'd2, occ: 4'b0010, free: 4'd3});
      wait_visit_end(2, "depart_v1");
      wait_sel(4'b1011, 100, "depart_v2_start");
      repeat (2) @(posedge clk);
      #1;
      scan_en = 1'b0;
      @(posedge clk);
      #1;
      check("pause_sel", 32'(slot_sel), 32'hF);
      repeat (5) @(posedge clk);
      #1;
      check("pause_sel_held", 32'(slot_sel), 32'hF);
      check("pause_occupied", 32'(occupied), 32'h6);
      scan_en = 1'b1;
      @(posedge clk);
      #1;
      check("resume_sel", 32'(slot_sel), 32'hB);
      wait_visit_end(2, "depart_v2");
      check("aborted_visit_uncounted", 32'(occupied), 32'h6);
      wait_sb_empty(200, "depart_seen");
      check("depart_event_held", 32'(event_slot), 32'd2);
      check("depart_occupied", 32'(occupied), 32'h2);
      check("depart_free_count", 32'(free_count), 32'd3);

      // Asynchronous reset away from any clock edge.
      wait_sel(4'b1101, 100, "rst_mid_start");
      repeat (5) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("amid_slot_sel", 32'(slot_sel), 32'hF);
      check("amid_occupied", 32'(occupied), 32'h0);
      check("amid_free_count", 32'(free_count), 32'd4);
      check("amid_occ_valid", 32'(occ_valid), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      // Slot 1 re-debounces during power-up with its event masked.
      repeat (250) @(posedge clk);
      #1;
      check("post_rst_occupied", 32'(occupied), 32'h2);
      check("post_rst_occ_valid", 32'(occ_valid), 32'd1);
      check("post_rst_event_slot", 32'(event_slot), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
